// File: rtl/test_harness.sv
// Built-in self-test: writes an LFSR sequence to a scratch RAM, reads it back and compares,
// while watching a differential reference pair for legs that sit at the same level.
module test_harness #(
   parameter int          DEPTH             = 64,
   parameter int          WIDTH             = 32,
   parameter logic [31:0] SEED              = 32'hACE1_0001,
   parameter int          PAIR_FAULT_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic io_VIP,
   input  logic io_VIN,
   output logic io_success
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(PAIR_FAULT_CYCLES + 1);
   localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [WIDTH-1:0] TAPS      = WIDTH'(32'h8020_0003);
   localparam logic [WIDTH-1:0] SEED_EFF  = (WIDTH'(SEED) == '0) ? WIDTH'(1) : WIDTH'(SEED);
   localparam logic [CW-1:0]    FAULT_CNT = CW'(PAIR_FAULT_CYCLES);

   typedef enum logic [2:0] {IDLE, WRITE, READ, DONE, FAIL} state_t;

   state_t           state_q;
   logic [AW-1:0]    addr_q;
   logic [WIDTH-1:0] lfsr_q;
   logic             issue_done_q;
   logic             rd_valid_q;
   logic             rd_last_q;
   logic [WIDTH-1:0] rdata_q;
   logic             success_q;
   logic             sync1_q;
   logic             sync2_q;
   logic [CW-1:0]    bad_cnt_q;
   logic             pair_fault;

   logic [WIDTH-1:0] mem [DEPTH];

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
      return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
   endfunction

   // Equal legs are the bad condition; the counter saturates at the fault threshold.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         bad_cnt_q <= '0;
      end else begin
         sync1_q <= ~(io_VIP ^ io_VIN);
         sync2_q <= sync1_q;
         if (!sync2_q)
            bad_cnt_q <= '0;
         else if (bad_cnt_q != FAULT_CNT)
            bad_cnt_q <= bad_cnt_q + CW'(1);
      end
   end

   assign pair_fault = (bad_cnt_q == FAULT_CNT);

   // Scratch RAM: contents survive reset, read data is always registered.
   always_ff @(posedge clock) begin
      if (state_q == WRITE)
         mem[addr_q] <= lfsr_q;
      rdata_q <= mem[addr_q];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         lfsr_q       <= SEED_EFF;
         issue_done_q <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         success_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= WRITE;
               addr_q  <= '0;
               lfsr_q  <= SEED_EFF;
            end
            WRITE: begin
               lfsr_q <= lfsr_step(lfsr_q);
               addr_q <= addr_q + AW'(1);
               if (addr_q == LAST_ADDR) begin
                  state_q      <= READ;
                  addr_q       <= '0;
                  lfsr_q       <= SEED_EFF;
                  issue_done_q <= 1'b0;
                  rd_valid_q   <= 1'b0;
               end
            end
            READ: begin
               if (!issue_done_q) begin
                  addr_q     <= addr_q + AW'(1);
                  rd_valid_q <= 1'b1;
                  rd_last_q  <= (addr_q == LAST_ADDR);
                  if (addr_q == LAST_ADDR)
                     issue_done_q <= 1'b1;
               end else begin
                  rd_valid_q <= 1'b0;
               end
               // rdata_q holds the word addressed on the previous edge.
               if (rd_valid_q) begin
                  if (rdata_q != lfsr_q) begin
                     state_q <= FAIL;
                  end else begin
                     lfsr_q <= lfsr_step(lfsr_q);
                     if (rd_last_q) begin
                        state_q   <= DONE;
                        success_q <= 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
         if (pair_fault && state_q != DONE && state_q != FAIL) begin
            state_q   <= FAIL;
            success_q <= 1'b0;
         end
      end
   end

   assign io_success = success_q;

endmodule

// File: tb/tb_test_harness.sv
// Randomized bench for test_harness: two builds (DEPTH 64 and 4) driven by the same reset and pair,
// each checked every edge against a window-based model of when success and failure occur.
module tb_test_harness;

   localparam int P = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bad = 1'b0;
   logic stuck = 1'b0;
   logic wave = 1'b0;
   logic vip, vin;
   logic succ64, succ4;

   int compared = 0;
   int mismatched = 0;

   int depths [2] = '{64, 4};
   bit done_m [2];
   bit failed_m [2];
   bit hist [16384];
   int n = 0;
   int burst = 0;

   always #5 clk = ~clk;

   // Same-frequency square wave, phase-shifted so no leg moves on a sampling edge.
   initial begin
      #2;
      forever #5 wave = ~wave;
   end

   assign vip = stuck ? 1'b0 : wave;
   assign vin = stuck ? 1'b0 : (bad ? wave : ~wave);

   test_harness #(.DEPTH(64), .WIDTH(32), .SEED(32'hACE1_0001), .PAIR_FAULT_CYCLES(P)) dut64 (
      .clock(clk), .reset(rst), .io_VIP(vip), .io_VIN(vin), .io_success(succ64)
   );

   test_harness #(.DEPTH(4), .WIDTH(32), .SEED(32'hACE1_0001), .PAIR_FAULT_CYCLES(P)) dut4 (
      .clock(clk), .reset(rst), .io_VIP(vip), .io_VIN(vin), .io_success(succ4)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s: edge %0d since release, got %0h expected %0h", tag, n, obs, exp);
      end
   endtask

   // Model: success appears at edge 2*DEPTH+2 after release; a run of P bad samples
   // starting at sample s fails the test at edge s+P+2 unless already done.
   task automatic step(input logic r, input logic b);
      bit win;
      rst = r;
      bad = b;
      @(posedge clk);
      #1;
      if (r) begin
         n = 0;
         for (int k = 0; k < 2; k++) begin
            done_m[k]   = 1'b0;
            failed_m[k] = 1'b0;
         end
      end else begin
         n++;
         hist[n] = b | stuck;
         for (int k = 0; k < 2; k++) begin
            if (!done_m[k] && !failed_m[k]) begin
               win = (n >= P + 2);
               if (win)
                  for (int j = n - P - 2; j <= n - 3; j++)
                     win = win & hist[j];
               if (win)
                  failed_m[k] = 1'b1;
               else if (n == 2 * depths[k] + 2)
                  done_m[k] = 1'b1;
            end
         end
      end
      check_eq("success_d64", {31'd0, succ64}, {31'd0, done_m[0]});
      check_eq("success_d4",  {31'd0, succ4},  {31'd0, done_m[1]});
   endtask

   task automatic run_good(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0);
   endtask

   initial begin
      // Reset state
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);

      // Nominal: rises after edge 130 (DEPTH 64) and 10 (DEPTH 4), then holds
      run_good(1130);

      // Reset while in DONE, then a full rerun
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      run_good(140);

      // Reset mid-WRITE at edge 20 for two cycles
      step(1'b1, 1'b0);
      run_good(20);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      run_good(140);

      // Glitch of P-1 equal-leg samples during WRITE must not fault
      step(1'b1, 1'b0);
      run_good(10);
      for (int i = 0; i < P - 1; i++) step(1'b0, 1'b1);
      run_good(130);

      // Fault landing on the same edge as the DEPTH-4 final compare, then one edge later
      for (int s = 4; s <= 5; s++) begin
         step(1'b1, 1'b0);
         run_good(s - 1);
         for (int i = 0; i < P; i++) step(1'b0, 1'b1);
         run_good(20);
      end

      // Randomized bursts of equal-leg samples and occasional resets
      for (int it = 0; it < 24; it++) begin
         burst = 0;
         step(1'b1, 1'b0);
         for (int e = 0; e < 150; e++) begin
            if ($urandom_range(0, 199) == 0) begin
               burst = 0;
               step(1'b1, 1'b0);
            end else begin
               if (burst == 0 && $urandom_range(0, 19) == 0)
                  burst = (it % 2 == 0) ? int'($urandom_range(1, P - 1))
                                        : int'($urandom_range(1, P + 2));
               if (burst > 0) begin
                  burst--;
                  step(1'b0, 1'b1);
               end else begin
                  step(1'b0, 1'b0);
               end
            end
         end
      end

      // Stuck pair from release: success must never rise
      step(1'b1, 1'b0);
      stuck = 1'b1;
      run_good(10000);
      stuck = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
